// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
// Holds the operation/state encodings and the operand magnitude helper.
package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_STEPS = 32;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } mul_state_e;

    // |v| when v is read as signed; 0x80000000 maps to itself, which is its unsigned magnitude
    function automatic logic [MUL_WIDTH-1:0] mag32(input logic [MUL_WIDTH-1:0] v,
                                                   input logic is_signed);
        logic [MUL_WIDTH-1:0] r;
        if (is_signed && v[MUL_WIDTH-1]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/add_32.sv
// 32-bit ripple-carry adder with carry-in tied low; cout is the 33rd sum bit.
module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s,
    output logic        cout
);

    logic [32:0] carry_s;

    assign carry_s[0] = 1'b0;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry_s[i]),
            .s    (s[i]),
            .cout (carry_s[i+1])
        );
    end

    assign cout = carry_s[32];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder, the ripple cell of add_32.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mul_seq_32.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU with a fixed 34-cycle latency.
// Works on operand magnitudes and restores the sign in a single FIX cycle.
module mul_seq_32
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    mul_state_e  state_r, next_state_s;
    mul_op_e     op_r;
    logic [31:0] mcand_r;
    logic [63:0] acc_r;
    logic [4:0]  count_r;
    logic        neg_r;
    logic        busy_r, valid_r;
    logic [31:0] result_r;

    logic        accept_s;
    logic        a_signed_s, b_signed_s;
    logic [31:0] add_sum_s;
    logic        add_cout_s;
    logic [32:0] partial_s;
    logic [63:0] step_s;
    logic [63:0] product_s;
    logic [31:0] result_sel_s;

    add_32 u_add (
        .a    (acc_r[63:32]),
        .b    (mcand_r),
        .s    (add_sum_s),
        .cout (add_cout_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; flush overrides every transition, including a start
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        if (flush) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        next_state_s = CALC;
                        accept_s     = 1'b1;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                CALC: begin
                    if (count_r == 5'(MUL_STEPS - 1)) begin
                        next_state_s = FIX;
                    end else begin
                        next_state_s = CALC;
                    end
                end
                FIX:  next_state_s = DONE;
                DONE: begin
                    if (start) begin
                        next_state_s = CALC;
                        accept_s     = 1'b1;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Operand signedness, one shift-add step and the signed result select
    always_comb begin
        a_signed_s = (op == 2'b01) || (op == 2'b10);
        b_signed_s = (op == 2'b01);
        if (acc_r[0]) begin
            partial_s = {add_cout_s, add_sum_s};
        end else begin
            partial_s = {1'b0, acc_r[63:32]};
        end
        step_s = {partial_s, acc_r[31:1]};
        if (neg_r) begin
            product_s = ~acc_r + 64'd1;
        end else begin
            product_s = acc_r;
        end
        if (op_r == MUL) begin
            result_sel_s = product_s[31:0];
        end else begin
            result_sel_s = product_s[63:32];
        end
    end

    // Operand capture on an accepted start, then one step per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r    <= MUL;
            mcand_r <= 32'd0;
            acc_r   <= 64'd0;
            count_r <= 5'd0;
            neg_r   <= 1'b0;
        end else if (accept_s) begin
            op_r    <= mul_op_e'(op);
            mcand_r <= mag32(a, a_signed_s);
            acc_r   <= {32'd0, mag32(b, b_signed_s)};
            count_r <= 5'd0;
            neg_r   <= (a_signed_s & a[31]) ^ (b_signed_s & b[31]);
        end else if (state_r == CALC) begin
            acc_r   <= step_s;
            count_r <= count_r + 5'd1;
        end else begin
            acc_r   <= acc_r;
            count_r <= count_r;
        end
    end

    // Registered outputs; result only changes on the FIX to DONE transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= 32'd0;
        end else begin
            busy_r  <= (next_state_s == CALC) || (next_state_s == FIX);
            valid_r <= (next_state_s == DONE);
            if ((state_r == FIX) && (next_state_s == DONE)) begin
                result_r <= result_sel_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign busy   = busy_r;
    assign valid  = valid_r;
    assign result = result_r;

endmodule

// File: tb/tb_mul_seq_32.sv
// Self-checking bench for mul_seq_32: directed table, corner sequences and random ops
// compared against a plain 64-bit arithmetic reference.
module tb_mul_seq_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    mul_seq_32 dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .valid(valid), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
        longint sx, ux, sy, uy, p;
        logic [63:0] pb;
        sx = longint'($signed(x));
        ux = longint'({32'd0, x});
        sy = longint'($signed(y));
        uy = longint'({32'd0, y});
        case (o)
            2'b00:   p = ux * uy;
            2'b01:   p = sx * sy;
            2'b10:   p = sx * uy;
            default: p = ux * uy;
        endcase
        pb = p;
        return (o == 2'b00) ? pb[31:0] : pb[63:32];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Drive a start so it is sampled at the next edge; returns in cycle 1 of the op
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Advance until valid (bounded), tracking the cycle number
    task automatic wait_valid(input int n0, output int n);
        n = n0;
        while (!valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    int n, busy_bad, seen_valid;
    logic [31:0] prev;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    initial begin
        vecs[0] = '{2'b00, 32'd7,          32'd6,          32'h0000002A};
        vecs[1] = '{2'b01, 32'h80000000,   32'h80000000,   32'h40000000};
        vecs[2] = '{2'b00, 32'h80000000,   32'h80000000,   32'h00000000};
        vecs[3] = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF};
        vecs[4] = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE};
        vecs[5] = '{2'b01, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFFF};
        vecs[6] = '{2'b00, 32'hFFFFFFFD,   32'd5,          32'hFFFFFFF1};
        vecs[7] = '{2'b01, 32'h00000000,   32'hFFFFFFFF,   32'h00000000};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'd0, busy},  32'd0);
        check("reset_valid",  {31'd0, valid}, 32'd0);
        check("reset_result", result,         32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Hand sequence: MUL 7*6 with the busy/valid profile checked every cycle
        issue(2'b00, 32'd7, 32'd6);
        n = 1;
        busy_bad = 0;
        while (n < 34) begin
            if (busy !== 1'b1 || valid !== 1'b0) busy_bad++;
            @(posedge clk);
            #1;
            n++;
        end
        check("busy_cycles_1_33", busy_bad, 32'd0);
        check("valid_cycle_34",   {31'd0, valid}, 32'd1);
        check("busy_cycle_34",    {31'd0, busy},  32'd0);
        check("mul_7x6",          result,         32'h0000002A);
        @(posedge clk);
        #1;
        check("valid_pulse_end",  {31'd0, valid}, 32'd0);

        // Directed table
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(1, n);
            check($sformatf("vec%0d_latency", i), n, 32'd34);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp);
            check($sformatf("vec%0d_model", i), result, ref_mul(vecs[i].op, vecs[i].a, vecs[i].b));
        end

        // Start while busy at cycle 10 is ignored
        issue(2'b00, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b11; a = 32'hDEADBEEF; b = 32'h12345678;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_valid(11, n);
        check("busy_start_latency", n, 32'd34);
        check("busy_start_result", result, 32'd7006652);

        // Flush at cycle 10: idle next cycle, no valid, result kept
        prev = result;
        issue(2'b01, 32'h11111111, 32'h22222222);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy_drop", {31'd0, busy}, 32'd0);
        seen_valid = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (valid) seen_valid++;
        end
        check("flush_no_valid", seen_valid, 32'd0);
        check("flush_result_held", result, prev);

        // Flush beats a simultaneous start in IDLE
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_beats_start", {31'd0, busy}, 32'd0);

        // Back-to-back: start in DONE gives a second valid 34 cycles later
        issue(2'b11, 32'h0000FFFF, 32'h00010001);
        wait_valid(1, n);
        check("b2b_first_result", result, ref_mul(2'b11, 32'h0000FFFF, 32'h00010001));
        start = 1'b1; op = 2'b00; a = 32'h00012345; b = 32'h00000100;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_valid_drop", {31'd0, valid}, 32'd0);
        wait_valid(1, n);
        check("b2b_second_latency", n, 32'd34);
        check("b2b_second_result", result, 32'h01234500);

        // Flush in DONE: valid still visible, new start blocked
        issue(2'b00, 32'd9, 32'd9);
        wait_valid(1, n);
        check("done_flush_valid_seen", {31'd0, valid}, 32'd1);
        start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("done_flush_no_busy",  {31'd0, busy},  32'd0);
        check("done_flush_no_valid", {31'd0, valid}, 32'd0);
        check("done_flush_result",   result,         32'd81);

        // Random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 6 == 0) ra = 32'h80000000;
            if (i % 7 == 3) rb = 32'h00000000;
            issue(ro, ra, rb);
            wait_valid(1, n);
            check($sformatf("rand%0d_latency", i), n, 32'd34);
            check($sformatf("rand%0d_op%0d_%08h_%08h", i, ro, ra, rb), result, ref_mul(ro, ra, rb));
        end

        // Reset mid-CALC clears outputs immediately
        issue(2'b00, 32'd100, 32'd200);
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_busy",   {31'd0, busy},  32'd0);
        check("rst_mid_valid",  {31'd0, valid}, 32'd0);
        check("rst_mid_result", result,         32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
